vga_fb_reader: RTL and testbench

Framebuffer scan-out stage that sits directly downstream of the VGA timing generator and feeds the DAC colour pins. It walks the framebuffer linearly, one word per pixel, and issues in-order read requests to the memory arbiter. Returned pixels are prefetched into a small FIFO. One pixel is popped per pixel strobe during the visible region, keeping the SRAM latency off the raster timing path.

---
 rtl/vga_fb_reader.sv | 105 ++++++++++
 tb/tb_vga_fb_reader.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/vga_fb_reader.sv
// vga_fb_reader: framebuffer scan-out with a credit-limited prefetch FIFO feeding the DAC.
// Define VGA_FB_UNDERFLOW_DBG_EN for magenta underflow pixels and an underflow_cnt output.
module vga_fb_reader #(
  parameter int DEPTH   = 16,
  parameter int PW      = 24,
  parameter int AW      = 19,
  parameter int FB_BASE = 0,
  parameter int NUM_PIX = 307200
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          pix_en,
  input  logic          vis,
  input  logic          frame_start,
  output logic          rd_req,
  output logic [AW-1:0] rd_addr,
  input  logic          rd_gnt,
  input  logic          rd_valid,
  input  logic [PW-1:0] rd_data,
  output logic [PW-1:0] vga_color,
`ifdef VGA_FB_UNDERFLOW_DBG_EN
  output logic [15:0]   underflow_cnt,
`endif
  output logic          underflow
);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int PTW = $clog2(DEPTH);
  localparam int IW  = $clog2(NUM_PIX + 1);
`ifdef VGA_FB_UNDERFLOW_DBG_EN
  localparam logic [PW-1:0] UNDERFLOW_COLOR = PW'(24'hFF00FF);
`else
  localparam logic [PW-1:0] UNDERFLOW_COLOR = '0;
`endif
  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_e;
  state_e state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d, out_q, out_d, drop_q, drop_d;
  logic [PTW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [15:0]    skip_q, skip_d;
  logic [PW-1:0]  color_q, color_d;
  logic           uf_q, uf_d;
  logic [PW-1:0]  mem_q [DEPTH];
  logic           xfer, resp, push, pop, pop_ok, pop_uf;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = frame_start ? FETCH :
              (state_q == FETCH && xfer && idx_q == IW'(NUM_PIX - 1)) ? DONE : state_q;
  // Outstanding reads reserve FIFO slots, so a response never finds the FIFO full
  always_comb
    rd_req = state_q == FETCH && ({1'b0, cnt_q} + {1'b0, out_q}) < (CW+1)'(DEPTH);
  assign xfer   = rd_req & rd_gnt;
  assign resp   = rd_valid & ~frame_start & (drop_q == '0);
  assign push   = resp & (skip_q == '0);
  assign pop    = pix_en & vis & ~frame_start;
  assign pop_ok = pop & (cnt_q != '0);
  assign pop_uf = pop & (cnt_q == '0);
  always_comb begin
    idx_d   = frame_start ? '0 : idx_q + IW'(xfer);
    out_d   = out_q + CW'(xfer) - CW'(rd_valid);
    drop_d  = frame_start ? out_d : drop_q - CW'(rd_valid && drop_q != '0);
    skip_d  = frame_start ? '0 : skip_q + 16'(pop_uf && skip_q != '1) - 16'(resp && skip_q != '0);
    cnt_d   = frame_start ? '0 : cnt_q + CW'(push) - CW'(pop_ok);
    wp_d    = frame_start ? '0 : wp_q + PTW'(push);
    rp_d    = frame_start ? '0 : rp_q + PTW'(pop_ok);
    color_d = (frame_start || (pix_en && !vis)) ? '0 :
              pop_ok ? mem_q[rp_q] : pop_uf ? UNDERFLOW_COLOR : color_q;
    uf_d    = uf_q | pop_uf;
  end
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      drop_q  <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      skip_q  <= '0;
      color_q <= '0;
      uf_q    <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      skip_q  <= skip_d;
      color_q <= color_d;
      uf_q    <= uf_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= rd_data;
`ifdef VGA_FB_UNDERFLOW_DBG_EN
  logic [15:0] ucnt_q;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) ucnt_q <= '0;
    else ucnt_q <= frame_start ? '0 : ucnt_q + 16'(pop_uf && ucnt_q != '1);
  assign underflow_cnt = ucnt_q;
`endif
  assign rd_addr   = AW'(FB_BASE) + AW'(idx_q);
  assign vga_color = color_q;
  assign underflow = uf_q;
endmodule

// File: tb/tb_vga_fb_reader.sv
// tb_vga_fb_reader: randomized bench with a queue-level model of memory, FIFO and raster.
// Honours VGA_FB_UNDERFLOW_DBG_EN for the underflow colour and underflow_cnt.
module tb_vga_fb_reader;
  localparam int DEPTH   = 4;
  localparam int PW      = 24;
  localparam int AW      = 12;
  localparam int FB_BASE = 160;
  localparam int NUM_PIX = 40;
`ifdef VGA_FB_UNDERFLOW_DBG_EN
  localparam logic [PW-1:0] UCOL = 24'hFF00FF;
`else
  localparam logic [PW-1:0] UCOL = '0;
`endif
  logic clk = 1'b0;
  logic rst_b, pix_en, vis, frame_start, rd_req, rd_gnt, rd_valid, underflow;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_data, vga_color;
`ifdef VGA_FB_UNDERFLOW_DBG_EN
  logic [15:0] underflow_cnt;
`endif
  vga_fb_reader #(.DEPTH(DEPTH), .PW(PW), .AW(AW), .FB_BASE(FB_BASE), .NUM_PIX(NUM_PIX)) dut (
    .clk(clk), .rst_b(rst_b), .pix_en(pix_en), .vis(vis), .frame_start(frame_start),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .vga_color(vga_color),
`ifdef VGA_FB_UNDERFLOW_DBG_EN
    .underflow_cnt(underflow_cnt),
`endif
    .underflow(underflow));
  always #5 clk = ~clk;
  typedef struct {logic [PW-1:0] d; bit stale; int due;} pend_t;
  pend_t pend[$];
  logic [PW-1:0] fifo[$];
  logic [PW-1:0] m_color;
  logic [15:0] m_ucnt;
  int m_skip, m_gr, m_ph, cyc, last_due, n_chk, n_err;
  bit m_uf, pe_tog;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask
  task automatic model_reset();
    pend.delete();
    fifo.delete();
    m_skip = 0; m_gr = 0; m_ph = 0; m_color = '0; m_uf = 0; m_ucnt = '0; last_due = 0;
  endtask
  task automatic chk_outputs(input string tag);
    chk({tag, "_color"}, 32'(vga_color), 32'(m_color));
    chk({tag, "_underflow"}, 32'(underflow), 32'(m_uf));
`ifdef VGA_FB_UNDERFLOW_DBG_EN
    chk({tag, "_ucnt"}, 32'(underflow_cnt), 32'(m_ucnt));
`endif
  endtask
  // One clock: drive, check request side, advance model on the edge, check pixel side
  task automatic step(input bit fs, input bit vi, input int gpct, input bit starve, input int lat);
    bit req, x, pe, g, val, pc, ski;
    logic [PW-1:0] pd;
    pend_t r;
    @(negedge clk);
    pe = pe_tog;
    pe_tog = !pe_tog;
    g = $urandom_range(99) < gpct;
    val = !starve && pend.size() > 0 && pend[0].due <= cyc;
    frame_start = fs; pix_en = pe; vis = vi; rd_gnt = g; rd_valid = val;
    rd_data = val ? pend[0].d : PW'($urandom);
    req = m_ph == 1 && fifo.size() + pend.size() < DEPTH;
    #1;
    chk("rd_req", 32'(rd_req), 32'(req));
    if (req) chk("rd_addr", 32'(rd_addr), 32'(FB_BASE + m_gr));
    @(posedge clk);
    x = req && g; pc = 0; ski = 0; pd = '0;
    if (val) begin
      r = pend.pop_front();
      pc = !r.stale && !fs;
      pd = r.d;
    end
    if (x) begin
      last_due = (cyc + lat > last_due) ? cyc + lat : last_due;
      pend.push_back('{d: PW'(FB_BASE + m_gr), stale: 1'b0, due: last_due});
    end
    if (fs) begin
      foreach (pend[i]) pend[i].stale = 1;
      fifo.delete();
      m_skip = 0; m_gr = 0; m_ph = 1; m_color = '0; m_ucnt = '0;
    end else begin
      if (pe && vi) begin
        if (fifo.size() > 0) m_color = fifo.pop_front();
        else begin
          m_color = UCOL; m_uf = 1; ski = 1;
          if (m_ucnt != 16'hFFFF) m_ucnt++;
        end
      end else if (pe) m_color = '0;
      if (pc) begin
        if (m_skip > 0) m_skip--;
        else fifo.push_back(pd);
      end
      m_skip += int'(ski);
      if (x) begin
        m_gr++;
        if (m_gr == NUM_PIX) m_ph = 2;
      end
    end
    cyc++;
    #1;
    chk_outputs("pix");
  endtask
  task automatic reset_mid();
    @(negedge clk);
    #2;
    rst_b = 0; frame_start = 0; pix_en = 0; vis = 0; rd_gnt = 0; rd_valid = 0;
    model_reset();
    #1;
    chk("async_rd_req", 32'(rd_req), 32'd0);
    chk("async_rd_addr", 32'(rd_addr), 32'(FB_BASE));
    chk_outputs("async");
    @(negedge clk);
    rst_b = 1;
  endtask
  initial begin
    n_chk = 0; n_err = 0; cyc = 0; pe_tog = 0;
    model_reset();
    rst_b = 0; frame_start = 0; pix_en = 0; vis = 0; rd_gnt = 0; rd_valid = 0; rd_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'(FB_BASE));
    chk_outputs("rst");
    rst_b = 1;
    repeat (6) step(0, 0, 100, 0, 3);
    step(1, 0, 100, 0, 3);
    repeat (20) step(0, 0, 100, 0, 3);
    repeat (2 * NUM_PIX) step(0, 1, 100, 0, 3);
    chk("clean_frame_underflow", 32'(underflow), 32'd0);
    repeat (8) step(0, 0, 100, 0, 3);
    step(1, 0, 100, 0, 3);
    repeat (10) step(0, 0, 0, 0, 3);
    repeat (12) step(0, 0, 100, 0, 3);
    repeat (12) step(0, 1, 100, 1, 3);
    repeat (12) step(0, 0, 100, 0, 3);
    repeat (20) step(0, 1, 100, 0, 3);
    step(1, 0, 100, 0, 8);
    repeat (3) step(0, 0, 100, 0, 8);
    step(1, 0, 100, 0, 3);
    repeat (30) step(0, 1, 100, 0, 3);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(199) == 0, $urandom_range(3) != 0, 75, $urandom_range(19) == 0,
           int'($urandom_range(6, 1)));
    step(1, 0, 100, 0, 6);
    repeat (3) step(0, 0, 100, 0, 6);
    reset_mid();
    repeat (8) step(0, 1, 100, 0, 3);
    step(1, 0, 100, 0, 3);
    for (int i = 0; i < 200; i++)
      step($urandom_range(99) == 0, $urandom_range(3) != 0, 80, 0, int'($urandom_range(4, 1)));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
